barrel_shift_pipe: RTL and testbench
====================================

# barrel_shift_pipe

Parametrised, pipelined element-granular barrel shifter with valid/ready flow control, selectable left/right direction and three fill modes: rotate, logical and arithmetic. It has one register stage per select bit, like the existing fixed 8-bit rotate shifter, and adds:
- element width and count as parameters;
- backpressure;
- a per-transaction tag passed through alongside the data.

It sits between a producer and consumer stream in the sort datapath.

## Interface
- `ELEM_W`, default 8: bits per element.
- `NUM`, default 16: elements per word. Must be a power of two and at least 2.
- `SEL_BITS`, default 4: equals log2(NUM). Sets the shift-amount width and the number of pipeline stages.
- `TAG_W`, default 4: width of the sideband tag.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input transaction present.
- `in_ready`  out  1  block accepts an input this cycle.
- `in_data`  in  ELEM_W*NUM  element j occupies bits [ELEM_W*j +: ELEM_W].
- `in_amt`  in  SEL_BITS  shift amount in elements, 0..NUM-1.
- `in_dir`  in  1  0 = left (toward higher index), 1 = right.
- `in_mode`  in  2  00 = rotate, 01 = logical, 10 = arithmetic, 11 = treated as rotate.
- `in_tag`  in  TAG_W  passed through unchanged.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  ELEM_W*NUM  shifted word.
- `out_tag`  out  TAG_W  tag of the transaction on `out_data`.

## Operation
- A transfer occurs on any edge where valid and ready are both high.
- Stage k (k = 0..SEL_BITS-1) shifts by 2^k elements when amt[k] = 1, otherwise it passes the word through. The stage-k output register holds data, amt, dir, mode, fill element, tag and a valid bit.
- Shift rules for amount s:
  - Left: out[j] = in[j-s].
  - Right: out[j] = in[j+s].
  - Rotate: indices wrap modulo NUM.
  - Logical and arithmetic: out-of-range positions take the fill element.
- Fill element:
  - Logical mode, and arithmetic mode with a left shift: all zeros.
  - Arithmetic mode with a right shift: ELEM_W copies of in_data[ELEM_W*NUM-1], the MSB of the top element.
  - The fill is computed once at the input from the original word and carried through every stage.
- Per-stage flow control: ready_k = ~valid_k | ready_(k+1), with ready_SEL_BITS = out_ready and in_ready = ready_0.
  - Stage k loads from upstream when ready_k is high. Its valid bit becomes the upstream valid.
  - When ready_k is low, stage k holds its contents.
- Ordering is strictly FIFO. No transaction is dropped or duplicated.
- While out_valid = 1 and out_ready = 0, out_data and out_tag must stay stable.
- The combinational path from out_ready to in_ready is permitted.
- in_amt = 0 gives the identity word in every mode.

## Timing
- Reset (asynchronous assert; release is synchronous to clk): all valid bits 0, all data/tag/control registers 0. out_valid = 0, out_data = 0, out_tag = 0, in_ready = 1.
- Latency: SEL_BITS cycles from the input transfer edge to out_valid high, when unstalled. Default is 4.
- Throughput: one transaction per cycle while out_ready = 1.
- Full pipeline with out_ready = 0: in_ready = 0 after SEL_BITS accepted transactions.
- out_ready rising on a full pipeline: one transaction drains and one enters on the same edge. No bubble is inserted.
- Reset asserted mid-operation: every in-flight transaction is discarded immediately and nothing is emitted after release.
- Control inputs are sampled only on the input transfer edge. Changes on cycles without a transfer are ignored.

## Test plan
Defaults apply (NUM = 16, ELEM_W = 8); element j of the input word = 0x0j unless stated.

- **Rotate left:** rotate left, amt = 3, tag = 5 -> out_valid exactly 4 cycles after the transfer; out[0] = 0x0D, out[3] = 0x00, out[15] = 0x0C; out_tag = 5.
- **Logical right:** logical right, amt = 4 -> out[0..11] = 0x04..0x0F and out[12..15] = 0x00.
- **Arithmetic right:** element 15 = 0x8F, arithmetic right, amt = 1 -> out[0..14] = 0x01..0x0E + 0x8F at index 14, out[15] = 0xFF. Repeated with element 15 = 0x7F -> out[15] = 0x00.
- **Arithmetic left:** arithmetic left, amt = 2 -> same result as logical left: out[0..1] = 0x00, out[2] = 0x00, out[3] = 0x01.
- **Backpressure:** 32 back-to-back random transactions with out_ready driven by a random 50% pattern, checked against a scoreboard -> in-order, bit-exact, no loss. in_ready = 0 after exactly 4 accepts while stalled. out_data stays stable during the stall.
- **Reset mid-flight:** 3 in flight, rst pulsed for 1 cycle -> out_valid = 0 and out_data = 0 immediately and nothing emitted afterwards. The next accepted transaction appears after exactly 4 cycles.

Source files
------------

// File: rtl/barrel_shift_pipe.sv
`timescale 1ns/1ps
// barrel_shift_pipe: element-granular barrel shifter with one register stage per
// shift-amount bit, valid/ready backpressure and a pass-through tag.
module barrel_shift_pipe #(
  parameter int ELEM_W   = 8,
  parameter int NUM      = 16,
  parameter int SEL_BITS = 4,
  parameter int TAG_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ELEM_W*NUM-1:0] in_data,
  input  logic [SEL_BITS-1:0]   in_amt,
  input  logic                  in_dir,
  input  logic [1:0]            in_mode,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_W*NUM-1:0] out_data,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int W = ELEM_W * NUM;
  localparam logic [1:0] MODE_LOG = 2'b01;
  localparam logic [1:0] MODE_ARI = 2'b10;

  // Per-stage output registers.
  logic [SEL_BITS-1:0] valid_q;
  logic [W-1:0]        data_q [SEL_BITS];
  logic [SEL_BITS-1:0] amt_q  [SEL_BITS];
  logic                dir_q  [SEL_BITS];
  logic [1:0]          mode_q [SEL_BITS];
  logic [ELEM_W-1:0]   fill_q [SEL_BITS];
  logic [TAG_W-1:0]    tag_q  [SEL_BITS];

  // Stage inputs: the block inputs for stage 0, the previous register otherwise.
  logic [SEL_BITS-1:0] src_valid;
  logic [W-1:0]        src_data [SEL_BITS];
  logic [SEL_BITS-1:0] src_amt  [SEL_BITS];
  logic                src_dir  [SEL_BITS];
  logic [1:0]          src_mode [SEL_BITS];
  logic [ELEM_W-1:0]   src_fill [SEL_BITS];
  logic [TAG_W-1:0]    src_tag  [SEL_BITS];

  logic [W-1:0]        data_d   [SEL_BITS];
  logic [SEL_BITS-1:0] ready_w;

  function automatic logic [W-1:0] shift_by(input logic [W-1:0]      w,
                                            input int                s,
                                            input logic              dir,
                                            input logic              rot,
                                            input logic [ELEM_W-1:0] fill);
    logic [W-1:0] r;
    int src;
    r = '0;
    for (int j = 0; j < NUM; j++) begin
      src = dir ? j + s : j - s;
      if (src >= 0 && src < NUM)
        r[ELEM_W*j +: ELEM_W] = w[ELEM_W*src +: ELEM_W];
      else if (rot)
        r[ELEM_W*j +: ELEM_W] = w[ELEM_W*((src + NUM) % NUM) +: ELEM_W];
      else
        r[ELEM_W*j +: ELEM_W] = fill;
    end
    return r;
  endfunction

  // A stage can take a new word if it is empty or its own word leaves this cycle.
  always_comb begin : ready_chain
    logic acc;
    acc = out_ready;
    for (int k = SEL_BITS - 1; k >= 0; k--) begin
      acc        = acc | ~valid_q[k];
      ready_w[k] = acc;
    end
  end

  // NOTE: every variable driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_amt[0]   = in_amt;
    src_dir[0]   = in_dir;
    src_mode[0]  = in_mode;
    src_tag[0]   = in_tag;
    src_fill[0]  = (in_mode == MODE_ARI && in_dir) ? {ELEM_W{in_data[W-1]}} : '0;
    for (int k = 1; k < SEL_BITS; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_amt[k]   = amt_q[k-1];
      src_dir[k]   = dir_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_fill[k]  = fill_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end
    for (int k = 0; k < SEL_BITS; k++) begin
      data_d[k] = src_amt[k][k]
                ? shift_by(src_data[k], 1 << k, src_dir[k],
                           !(src_mode[k] == MODE_LOG || src_mode[k] == MODE_ARI),
                           src_fill[k])
                : src_data[k];
    end
  end

  // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
  // NOTE: data and control registers are cleared too, so out_data reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SEL_BITS; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        dir_q[k]  <= 1'b0;
        mode_q[k] <= '0;
        fill_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < SEL_BITS; k++) begin
        if (ready_w[k]) begin
          valid_q[k] <= src_valid[k];
          data_q[k]  <= data_d[k];
          amt_q[k]   <= src_amt[k];
          dir_q[k]   <= src_dir[k];
          mode_q[k]  <= src_mode[k];
          fill_q[k]  <= src_fill[k];
          tag_q[k]   <= src_tag[k];
        end
      end
    end
  end

  assign in_ready  = ready_w[0];
  assign out_valid = valid_q[SEL_BITS-1];
  assign out_data  = data_q[SEL_BITS-1];
  assign out_tag   = tag_q[SEL_BITS-1];

endmodule

// File: tb/tb_barrel_shift_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for barrel_shift_pipe: directed shifts, backpressure with a
// scoreboard, stall stability and mid-flight reset.
module tb_barrel_shift_pipe;

  localparam int ELEM_W   = 8;
  localparam int NUM      = 16;
  localparam int SEL_BITS = 4;
  localparam int TAG_W    = 4;
  localparam int W        = ELEM_W * NUM;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        in_data;
  logic [SEL_BITS-1:0] in_amt;
  logic                in_dir;
  logic [1:0]          in_mode;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_data;
  logic [TAG_W-1:0]    out_tag;

  always #5 clk = ~clk;

  barrel_shift_pipe #(
    .ELEM_W(ELEM_W), .NUM(NUM), .SEL_BITS(SEL_BITS), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  typedef struct packed {
    logic [W-1:0]     data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;

  task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference: whole-amount shift computed directly from the index rules.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s,
                                         input logic dir, input logic [1:0] mode);
    logic [W-1:0] r;
    logic [7:0]   fill;
    int           src;
    fill = (mode == 2'b10 && dir) ? {8{d[W-1]}} : 8'h00;
    r = '0;
    for (int j = 0; j < NUM; j++) begin
      src = dir ? j + s : j - s;
      if (mode == 2'b01 || mode == 2'b10) begin
        if (src < 0 || src >= NUM) r[8*j +: 8] = fill;
        else                       r[8*j +: 8] = d[8*src +: 8];
      end else begin
        r[8*j +: 8] = d[8*(((src % NUM) + NUM) % NUM) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] el(input logic [W-1:0] w, input int j);
    return w[8*j +: 8];
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Output monitor and input recorder, both sampled on the falling edge.
  logic [W-1:0]     prev_data;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("stall_data_stable", out_data, prev_data);
        check("stall_tag_stable", W'(out_tag), W'(prev_tag));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          check("unexpected_output", W'(out_valid), '0);
        end else begin
          sb_e = sb.pop_front();
          check("sb_data", out_data, sb_e.data);
          check("sb_tag", W'(out_tag), W'(sb_e.tag));
        end
      end
      if (in_valid && in_ready)
        sb.push_back('{data: model(in_data, int'(in_amt), in_dir, in_mode), tag: in_tag});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_tag   = out_tag;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that transferred.
  task automatic send(input logic [W-1:0] d, input logic [SEL_BITS-1:0] a,
                      input logic dir, input logic [1:0] mode, input logic [TAG_W-1:0] tag);
    int n;
    n        = 0;
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_mode  = mode;
    in_tag   = tag;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 50);
    if (!out_valid) check("out_timeout", W'(out_valid), W'(1));
  endtask

  logic [W-1:0] base, d, exp_w;
  int           cyc, accepts, seen, n0;
  bit           drv_done;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0;
    in_dir = 1'b0; in_mode = 2'b00; in_tag = '0; out_ready = 1'b1;
    for (int j = 0; j < NUM; j++) base[8*j +: 8] = 8'(j);

    repeat (2) @(negedge clk);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_tag", W'(out_tag), '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    step();
    rst = 1'b0;

    // Rotate left by 3, latency and tag.
    send(base, 4'd3, 1'b0, 2'b00, 4'd5);
    in_valid = 1'b0;
    wait_out(cyc);
    check("rotl_latency", W'(cyc), W'(4));
    check("rotl_el0", W'(el(out_data, 0)), W'(8'h0D));
    check("rotl_el3", W'(el(out_data, 3)), W'(8'h00));
    check("rotl_el15", W'(el(out_data, 15)), W'(8'h0C));
    check("rotl_tag", W'(out_tag), W'(5));

    // Logical right by 4.
    step();
    send(base, 4'd4, 1'b1, 2'b01, 4'd1);
    in_valid = 1'b0;
    wait_out(cyc);
    for (int j = 0; j < NUM; j++) exp_w[8*j +: 8] = (j < 12) ? 8'(j + 4) : 8'h00;
    check("lsr_word", out_data, exp_w);

    // Arithmetic right by 1, negative then positive top element.
    step();
    d = base; d[8*15 +: 8] = 8'h8F;
    send(d, 4'd1, 1'b1, 2'b10, 4'd2);
    in_valid = 1'b0;
    wait_out(cyc);
    for (int j = 0; j < 14; j++) exp_w[8*j +: 8] = 8'(j + 1);
    exp_w[8*14 +: 8] = 8'h8F;
    exp_w[8*15 +: 8] = 8'hFF;
    check("asr_neg_word", out_data, exp_w);
    check("asr_neg_el15", W'(el(out_data, 15)), W'(8'hFF));

    step();
    d[8*15 +: 8] = 8'h7F;
    send(d, 4'd1, 1'b1, 2'b10, 4'd3);
    in_valid = 1'b0;
    wait_out(cyc);
    exp_w[8*14 +: 8] = 8'h7F;
    exp_w[8*15 +: 8] = 8'h00;
    check("asr_pos_word", out_data, exp_w);

    // Arithmetic left by 2 equals logical left.
    step();
    send(base, 4'd2, 1'b0, 2'b10, 4'd4);
    in_valid = 1'b0;
    wait_out(cyc);
    for (int j = 0; j < NUM; j++) exp_w[8*j +: 8] = (j < 2) ? 8'h00 : 8'(j - 2);
    check("asl_word", out_data, exp_w);
    check("asl_el3", W'(el(out_data, 3)), W'(8'h01));

    // Amount 0 is identity in every mode.
    for (int m = 0; m < 4; m++) begin
      step();
      d = rand_word();
      send(d, 4'd0, 1'b1, 2'(m), 4'(m));
      in_valid = 1'b0;
      wait_out(cyc);
      check("amt0_identity", out_data, d);
    end

    // Stall: pipeline fills with exactly SEL_BITS transactions.
    step();
    out_ready = 1'b0;
    accepts   = 0;
    in_data = rand_word(); in_amt = 4'($urandom); in_dir = 1'($urandom);
    in_mode = 2'($urandom); in_tag = 4'($urandom); in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (in_ready) begin
        accepts++;
        @(posedge clk); #1;
        in_data = rand_word(); in_amt = 4'($urandom); in_dir = 1'($urandom);
        in_mode = 2'($urandom); in_tag = 4'($urandom);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("stall_accepts", W'(accepts), W'(SEL_BITS));
    check("stall_in_ready", W'(in_ready), '0);
    check("stall_out_valid", W'(out_valid), W'(1));
    repeat (3) @(negedge clk);
    // Releasing out_ready lets one leave and one enter on the same edge.
    step();
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", W'(in_ready), W'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("release_no_bubble", W'(out_valid), W'(1));
    for (int c = 0; c < 100 && sb.size() > 0; c++) @(negedge clk);
    check("stall_drained", W'(sb.size()), '0);

    // Random backpressure, 32 back-to-back transactions.
    step();
    n0 = n_out;
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++)
          send(rand_word(), 4'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
        in_valid = 1'b0;
        drv_done = 1'b1;
      end
      begin
        for (int c = 0; c < 2000 && !(drv_done && sb.size() == 0); c++) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    check("bp_drained", W'(sb.size()), '0);
    check("bp_count", W'(n_out - n0), W'(32));

    // Reset with three transactions in flight.
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      send(rand_word(), 4'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), '0);
    check("midrst_out_data", out_data, '0);
    sb.delete();
    step();
    rst  = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrst_nothing_emitted", W'(seen), '0);
    step();
    send(base, 4'd5, 1'b0, 2'b01, 4'd9);
    in_valid = 1'b0;
    wait_out(cyc);
    check("midrst_latency", W'(cyc), W'(4));
    check("midrst_tag", W'(out_tag), W'(9));
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
